level_sequencer: RTL
====================

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameter WINDOW, default 1024: the number of accepted samples per evaluation window (range 2..65535).
REQ-002 Parameter HOLD_WINDOWS, default 4: the number of windows a new peak is held before decay starts (range 0..15).
REQ-003 clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sample_valid  in  1  one-cycle strobe; wave_sample is valid in that cycle.
REQ-006 wave_sample  in  10  unsigned audio sample; 512 is silence.
REQ-007 freeze  in  1  when high, samples are ignored and lvl1 holds its value.
REQ-008 frame_start  in  1  one-cycle pulse at VGA frame start, synchronous to clk.
REQ-009 lvl1  out  4  display level for the circle renderer; registered.
REQ-010 lvl_update  out  1  one-cycle pulse in the cycle lvl1 is loaded.
REQ-011 win_done  out  1  one-cycle pulse when a window evaluation completes.

Function
REQ-012 The block SHALL compute amp = |wave_sample − 512| and saturate it to 511 (9 bits), so that wave_sample = 0 gives 511.
REQ-013 States: IDLE → ACCUM on the first accepted sample; ACCUM → EVAL after the WINDOW-th accepted sample; EVAL → ACCUM after one cycle.
REQ-014 A sample is accepted only when sample_valid=1 and freeze=0; in ACCUM, win_max <= max(win_max, amp) and cnt increments.
REQ-015 A sample accepted in the EVAL cycle SHALL seed the next window (win_max = its amp, cnt = 1) and SHALL NOT be lost.
REQ-016 In EVAL: wlvl = win_max[8:5] (0..15); win_done=1; win_max and cnt clear unless REQ-015 applies.
REQ-017 Hold/decay in EVAL: if wlvl ≥ held, then held <= wlvl and hold_cnt <= HOLD_WINDOWS; else if hold_cnt > 0, hold_cnt decrements; else held <= max(held − 1, wlvl).
REQ-018 lvl1 SHALL change only in a cycle with frame_start=1 and freeze=0, loading held; lvl_update is asserted in that same cycle.
REQ-019 If frame_start and EVAL coincide, lvl1 SHALL load the pre-EVAL held value; the new held value appears at the next frame_start.
REQ-020 While freeze=1, state, cnt, win_max, held and lvl1 SHALL all be unchanged; on release, accumulation resumes with the stored cnt.
REQ-021 cnt SHALL be 16 bits and SHALL never exceed WINDOW; held SHALL never underflow below 0 or exceed 15.

Reset
REQ-022 When reset=1 at a clock edge: state=IDLE, cnt=0, win_max=0, held=0, hold_cnt=0, lvl1=0, lvl_update=0, win_done=0.
REQ-023 Reset SHALL take priority over every other input, including mid-window and mid-EVAL; a partial window SHALL be discarded.

Structure
REQ-024 The package viz_pkg SHALL hold LVL_W=4, SAMPLE_MID=512, AMP_W=9 and the state enum {IDLE, ACCUM, EVAL}.
REQ-025 A sub-module peak_detect SHALL hold the amp computation, the window max and the counter, and SHALL signal window-full.
REQ-026 The top level SHALL hold the FSM, the hold/decay logic and the frame-synchronous lvl1 register.

Verification (bench: WINDOW=4, HOLD_WINDOWS=2)
REQ-027 Samples 512, 600, 1023, 0, then frame_start → win_max=511, wlvl=15, lvl1=15 after frame_start, lvl_update one pulse.
REQ-028 After a level-15 window, four windows of constant 512, each followed by frame_start → lvl1 sequence 15, 15, 14, 13 (two hold windows, then −1 per window).
REQ-029 sample_valid asserted in the EVAL cycle with wave_sample=704 → next window starts with cnt=1 and win_max=192; no sample is dropped.
REQ-030 freeze=1 for 10 samples and 3 frame_start pulses → lvl1, cnt and held are unchanged; after release the window completes on the remaining count.
REQ-031 reset pulsed after 2 of 4 samples, with a prior lvl1=9 → all outputs are 0 next cycle; the next window needs 4 fresh samples.
REQ-032 frame_start coincident with EVAL that raises held 3→12 → lvl1=3 at that frame and 12 at the following frame_start.

Source files
------------

// File: rtl/viz_pkg.sv
// Shared constants and state encoding for the audio level visualiser.
package viz_pkg;
   localparam int LVL_W      = 4;
   localparam int SAMPLE_MID = 512;
   localparam int AMP_W      = 9;

   typedef enum logic [1:0] {IDLE, ACCUM, EVAL} state_t;
endpackage

// File: rtl/peak_detect.sv
// Per-window peak amplitude tracker: |sample - mid| saturated, running max and sample count.
module peak_detect
   import viz_pkg::*;
#(
   parameter int WINDOW = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_accept,
   input  logic             i_restart,
   input  logic [9:0]       i_sample,
   output logic [LVL_W-1:0] o_wlvl,
   output logic             o_full
);
   logic [9:0]       w_diff;
   logic [AMP_W-1:0] w_amp;
   logic [AMP_W-1:0] r_win_max;
   logic [15:0]      r_cnt;

   always_comb begin
      if (i_sample >= 10'(SAMPLE_MID)) w_diff = i_sample - 10'(SAMPLE_MID);
      else                             w_diff = 10'(SAMPLE_MID) - i_sample;
   end

   // Only sample 0 reaches 512; clamp so the max fits in 9 bits.
   assign w_amp  = (w_diff > 10'd511) ? 9'd511 : w_diff[AMP_W-1:0];
   assign o_wlvl = r_win_max[AMP_W-1 -: LVL_W];
   assign o_full = i_accept && (r_cnt == 16'(WINDOW - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_win_max <= '0;
         r_cnt     <= '0;
      end else if (i_restart) begin
         // A sample arriving during evaluation seeds the next window.
         r_win_max <= i_accept ? w_amp : '0;
         r_cnt     <= i_accept ? 16'd1 : 16'd0;
      end else if (i_accept) begin
         if (w_amp > r_win_max) r_win_max <= w_amp;
         r_cnt <= r_cnt + 16'd1;
      end
   end
endmodule

// File: rtl/level_sequencer.sv
// Window FSM, peak hold/decay and frame-synchronous display level register.
module level_sequencer
   import viz_pkg::*;
#(
   parameter int WINDOW       = 1024,
   parameter int HOLD_WINDOWS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_valid,
   input  logic [9:0]       wave_sample,
   input  logic             freeze,
   input  logic             frame_start,
   output logic [LVL_W-1:0] lvl1,
   output logic             lvl_update,
   output logic             win_done
);
   state_t           r_state;
   logic [LVL_W-1:0] r_held;
   logic [3:0]       r_hold_cnt;
   logic [LVL_W-1:0] w_wlvl;
   logic             w_full;
   logic             w_accept;
   logic             w_eval;

   assign w_accept = sample_valid && !freeze;
   assign w_eval   = (r_state == EVAL) && !freeze;
   assign win_done = w_eval;

   peak_detect #(.WINDOW(WINDOW)) u_pd (
      .clk       (clk),
      .reset     (reset),
      .i_accept  (w_accept),
      .i_restart (w_eval),
      .i_sample  (wave_sample),
      .o_wlvl    (w_wlvl),
      .o_full    (w_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_accept) r_state <= ACCUM;
            ACCUM:   if (w_full)   r_state <= EVAL;
            EVAL:    if (!freeze)  r_state <= ACCUM;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_held     <= '0;
         r_hold_cnt <= '0;
      end else if (w_eval) begin
         if (w_wlvl >= r_held) begin
            r_held     <= w_wlvl;
            r_hold_cnt <= 4'(HOLD_WINDOWS);
         end else if (r_hold_cnt != 4'd0) begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
         end else begin
            r_held <= ((r_held - 4'd1) > w_wlvl) ? (r_held - 4'd1) : w_wlvl;
         end
      end
   end

   // Loads the pre-update held value when a frame and an evaluation coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         lvl1       <= '0;
         lvl_update <= 1'b0;
      end else begin
         lvl_update <= frame_start && !freeze;
         if (frame_start && !freeze) lvl1 <= r_held;
      end
   end
endmodule
